// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The loader receives a byte-stream program image and writes it to the core's instruction memory.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_CNT_LO = 3'd0,
    S_CNT_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_BYTES      = 2;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs little-endian bytes into 32-bit words.
// word_valid_o is combinational and presents the complete word in the same cycle that the 4th byte arrives.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic [31:0]           word_o,
  output logic                  word_valid_o,
  output logic [BYTE_IDX_W-1:0] byte_idx_o
);

  localparam int LANE_BITS = 8 * (BYTES_PER_WORD - 1);

  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [LANE_BITS-1:0]  lanes_q, lanes_d;

  // Only the lower three lanes are stored; the top lane is taken directly from the 4th byte.
  always_comb begin
    byte_idx_d = byte_idx_q;
    lanes_d    = lanes_q;
    if (clear_i) begin
      byte_idx_d = '0;
      lanes_d    = '0;
    end else if (byte_valid_i) begin
      byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
      case (byte_idx_q)
        2'd0:    lanes_d[7:0]   = byte_i;
        2'd1:    lanes_d[15:8]  = byte_i;
        2'd2:    lanes_d[23:16] = byte_i;
        default: lanes_d        = lanes_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q <= '0;
      lanes_q    <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      lanes_q    <= lanes_d;
    end
  end

  assign word_valid_o = byte_valid_i && !clear_i &&
                        (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  assign word_o       = {byte_i, lanes_q};
  assign byte_idx_o   = byte_idx_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a counted, XOR-checksummed program image into instruction memory.
// The core is held in reset until a verified image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int IMEM_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  load_start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [INST_WIDTH-1:0] imem_wdata,
  output logic                  cpu_rst_n,
  output logic                  load_done,
  output logic                  load_err,
  output state_e                dbg_state_o
);

  localparam int WIDX_W = $clog2(IMEM_DEPTH) + 1;

  // Handshake: a byte moves on a rising edge where rx_valid && rx_ready; rx_ready never depends on rx_valid.
  state_e                state_q;
  logic [8*CNT_BYTES-1:0] cnt_q;
  logic [WIDX_W-1:0]     word_idx_q;
  logic [7:0]            chk_q;
  logic                  rx_ready_q;
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [INST_WIDTH-1:0] imem_wdata_q;
  logic                  cpu_rst_n_q;
  logic                  load_done_q;
  logic                  load_err_q;

  logic                  accept;
  logic                  rearm;
  logic [15:0]           cnt_full;
  logic                  cnt_too_big;
  logic                  last_word;
  logic [31:0]           packed_word;
  logic                  word_valid;
  logic [BYTE_IDX_W-1:0] byte_idx;

  assign accept      = rx_valid && rx_ready_q;
  assign rearm       = load_start && ((state_q == S_DONE) || (state_q == S_ERROR));
  assign cnt_full    = {rx_data, cnt_q[7:0]};
  assign cnt_too_big = {1'b0, cnt_full} > 17'(IMEM_DEPTH);
  assign last_word   = (16'(word_idx_q) + 16'd1) == cnt_q;

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (rearm),
    .byte_valid_i (accept && (state_q == S_DATA)),
    .byte_i       (rx_data),
    .word_o       (packed_word),
    .word_valid_o (word_valid),
    .byte_idx_o   (byte_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_CNT_LO;
      cnt_q        <= '0;
      word_idx_q   <= '0;
      chk_q        <= '0;
      rx_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_n_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_CNT_LO: begin
          if (accept) begin
            cnt_q[7:0] <= rx_data;
            state_q    <= S_CNT_HI;
          end
        end
        S_CNT_HI: begin
          if (accept) begin
            cnt_q[15:8] <= rx_data;
            if (cnt_too_big) begin
              state_q    <= S_ERROR;
              rx_ready_q <= 1'b0;
              load_err_q <= 1'b1;
            end else if (cnt_full == 16'd0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            chk_q <= chk_q ^ rx_data;
            if (word_valid) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= ADDR_WIDTH'(word_idx_q);
              imem_wdata_q <= INST_WIDTH'(packed_word);
              word_idx_q   <= word_idx_q + WIDX_W'(1);
              if (last_word) state_q <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (accept) begin
            rx_ready_q <= 1'b0;
            if (rx_data == chk_q) begin
              state_q     <= S_DONE;
              load_done_q <= 1'b1;
              cpu_rst_n_q <= 1'b1;
            end else begin
              state_q    <= S_ERROR;
              load_err_q <= 1'b1;
            end
          end
        end
        S_DONE, S_ERROR: begin
          // Memory contents are deliberately left intact on re-arm.
          if (load_start) begin
            state_q     <= S_CNT_LO;
            rx_ready_q  <= 1'b1;
            cpu_rst_n_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            cnt_q       <= '0;
            word_idx_q  <= '0;
            chk_q       <= '0;
          end
        end
        default: begin
          state_q    <= S_CNT_LO;
          rx_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign rx_ready    = rx_ready_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign cpu_rst_n   = cpu_rst_n_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;
  assign dbg_state_o = state_q;

  logic unused_ok;
  assign unused_ok = ^byte_idx;

endmodule
